// File: rtl/logarithm.sv
// Sequential natural-log unit: ln(y) of an unsigned 2.FRAC operand in [1.0, e).
// Multiplicative normalization: one (1+2^-k) factor tried per cycle, ln of the accepted factors summed from a ROM.
module logarithm #(
  parameter int FRAC  = 16,
  parameter int ITER  = 16,
  parameter int GUARD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [FRAC+1:0] y_in,
  output logic            done,
  output logic            busy,
  output logic            err,
  output logic [FRAC-1:0] result
);

  localparam int WF = FRAC + GUARD;
  localparam int PW = WF + 2;
  localparam int AW = WF + 1;
  localparam int KW = $clog2(ITER + 1);

  localparam logic [FRAC+1:0] ONE_Y  = {2'b01, {FRAC{1'b0}}};
  localparam logic [FRAC+1:0] E_Q    = 18'h2B7E1;
  localparam logic [PW-1:0]   ONE_P  = {2'b01, {WF{1'b0}}};
  localparam logic [KW-1:0]   K_LAST = KW'(ITER);

  // round(ln(1+2^-k) * 2^20) for the default FRAC+GUARD of 20 bits
  localparam logic [WF-1:0] LN_ROM [32] = '{
    20'd726817, 20'd425161, 20'd233983, 20'd123504, 20'd63570, 20'd32266,
    20'd16257,  20'd8160,   20'd4088,   20'd2046,   20'd1024,  20'd512,
    20'd256,    20'd128,    20'd64,     20'd32,     20'd16,    20'd8,
    20'd4,      20'd2,      20'd1,      20'd0,      20'd0,     20'd0,
    20'd0,      20'd0,      20'd0,      20'd0,      20'd0,     20'd0,
    20'd0,      20'd0
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [FRAC+1:0] yR_q, yR_d;
  logic [PW-1:0]   p_q, p_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [KW-1:0]   k_q, k_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [FRAC-1:0] result_q, result_d;

  logic [PW:0]     tSum;
  logic [PW:0]     yExt;
  logic [AW-1:0]   accNext;
  logic [FRAC:0]   rounded;
  logic [4:0]      romIdx;

  assign romIdx = 5'(k_q);
  assign yExt   = {1'b0, yR_q, {GUARD{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      yR_q     <= '0;
      p_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      yR_q     <= yR_d;
      p_q      <= p_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    yR_d     = yR_q;
    p_d      = p_q;
    acc_d    = acc_q;
    k_d      = k_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
    tSum     = {1'b0, p_q} + ({1'b0, p_q} >> k_q);
    accNext  = acc_q;
    rounded  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          yR_d = y_in;
          if (y_in < ONE_Y) begin
            err_d    = 1'b1;
            result_d = '0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (y_in >= E_Q) begin
            err_d    = 1'b1;
            result_d = '1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            p_d     = ONE_P;
            acc_d   = '0;
            k_d     = '0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // Take the factor only while the running product stays at or below the operand
        if (tSum <= yExt) begin
          p_d     = tSum[PW-1:0];
          accNext = acc_q + AW'(LN_ROM[romIdx]);
        end
        acc_d = accNext;
        k_d   = k_q + KW'(1);
        if (k_q == K_LAST) begin
          rounded  = accNext[AW-1:GUARD] + (FRAC+1)'(accNext[GUARD-1]);
          result_d = rounded[FRAC] ? '1 : rounded[FRAC-1:0];
          err_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign done   = done_q;
  assign busy   = (state_q == RUN);
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_logarithm.sv
// Self-checking bench for the logarithm unit: directed table, handshake and reset
// sequences, and a random sweep against a real-valued ln reference.
module tb_logarithm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [17:0] y_in;
  logic        done;
  logic        busy;
  logic        err;
  logic [15:0] result;

  int nCompared   = 0;
  int nMismatched = 0;

  logarithm dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .y_in   (y_in),
    .done   (done),
    .busy   (busy),
    .err    (err),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] y;
    logic        expErr;
    logic [15:0] expRes;
    real         tol;
    int          expEdges;
  } vec_t;

  vec_t vecs[9];

  // Reference: ln of the 2.16 operand, scaled to a 0.16 fraction and clamped to all ones
  function automatic real lnModel(input logic [17:0] y);
    real r;
    r = $ln(real'(y) / 65536.0) * 65536.0;
    if (r > 65535.0) r = 65535.0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input real actual, input real expected, input real tol);
    real d;
    d = actual - expected;
    if (d < 0.0) d = -d;
    nCompared++;
    if (d > tol) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0.2f, required %0.2f +/- %0.2f", name, actual, expected, tol);
    end
  endtask

  // Runs one operation with start held until done, then drops start and checks done clears
  task automatic applyStimulus(input logic [17:0] y, output logic [15:0] res, output logic e,
                               output int edges);
    @(negedge clk);
    y_in  = y;
    start = 1'b1;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
    end
    res = result;
    e   = err;
    checkOutput("done_seen", real'(done), 1.0, 0.0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("done_clears", real'(done), 0.0, 0.0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] res;
    logic        e;
    int          edges;
    int          badCycles;
    logic [17:0] y;
    logic [15:0] heldRes;

    vecs[0] = '{18'h10000, 1'b0, 16'h0000, 0.0, 18};
    vecs[1] = '{18'h20000, 1'b0, 16'hB172, 4.0, 18};
    vecs[2] = '{18'h1A613, 1'b0, 16'h8000, 4.0, 18};
    vecs[3] = '{18'h0FFFF, 1'b1, 16'h0000, 0.0, 1};
    vecs[4] = '{18'h2B7E1, 1'b1, 16'hFFFF, 0.0, 1};
    vecs[5] = '{18'h00000, 1'b1, 16'h0000, 0.0, 1};
    vecs[6] = '{18'h3FFFF, 1'b1, 16'hFFFF, 0.0, 1};
    vecs[7] = '{18'h2B7E0, 1'b0, 16'hFFFF, 4.0, 18};
    vecs[8] = '{18'h18000, 1'b0, 16'h67CD, 4.0, 18};

    rst   = 1'b1;
    start = 1'b0;
    y_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_done", real'(done), 0.0, 0.0);
    checkOutput("reset_busy", real'(busy), 0.0, 0.0);
    checkOutput("reset_err", real'(err), 0.0, 0.0);
    checkOutput("reset_result", real'(result), 0.0, 0.0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: result, error flag and latency counted from the accepting edge
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].y, res, e, edges);
      checkOutput($sformatf("vec%0d_result", i), real'(res), real'(vecs[i].expRes), vecs[i].tol);
      checkOutput($sformatf("vec%0d_err", i), real'(e), real'(vecs[i].expErr), 0.0);
      checkOutput($sformatf("vec%0d_latency", i), real'(edges), real'(vecs[i].expEdges), 0.0);
    end

    // Round trip: operand built from exp(x), result must come back to x
    for (int i = 1; i < 4; i++) begin
      real x;
      x = real'(i) * 16384.0;
      y = 18'($rtoi($exp(x / 65536.0) * 65536.0 + 0.5));
      applyStimulus(y, res, e, edges);
      checkOutput($sformatf("roundtrip_%0d", i), real'(res), x, 5.0);
    end

    // Start held high: one operation only, done stays up, no re-trigger
    @(negedge clk);
    y_in  = 18'h24000;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    checkOutput("held_done", real'(done), 1.0, 0.0);
    heldRes   = result;
    badCycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (!done || busy || result != heldRes) badCycles++;
    end
    checkOutput("held_no_retrigger", real'(badCycles), 0.0, 0.0);
    checkOutput("held_result", real'(heldRes), lnModel(18'h24000), 4.0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("held_release", real'(done), 0.0, 0.0);
    applyStimulus(18'h1C000, res, e, edges);
    checkOutput("after_held_result", real'(res), lnModel(18'h1C000), 4.0);

    // Reset in the middle of a run aborts everything at once
    applyStimulus(18'h20000, res, e, edges);
    @(negedge clk);
    y_in  = 18'h1C000;
    start = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midrun_busy", real'(busy), 1.0, 0.0);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_done", real'(done), 0.0, 0.0);
    checkOutput("abort_busy", real'(busy), 0.0, 0.0);
    checkOutput("abort_err", real'(err), 0.0, 0.0);
    checkOutput("abort_result", real'(result), 0.0, 0.0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;

    // Restart; y_in is scrambled mid-run and must not matter
    @(negedge clk);
    y_in  = 18'h1C000;
    start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 y_in = 18'h3FFFF;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    checkOutput("restart_done", real'(done), 1.0, 0.0);
    checkOutput("restart_result", real'(result), lnModel(18'h1C000), 4.0);
    checkOutput("restart_err", real'(err), 0.0, 0.0);
    @(negedge clk);
    start = 1'b0;

    // Random sweep over the valid range
    for (int i = 0; i < 150; i++) begin
      y = 18'($urandom_range(32'h2B7E0, 32'h10000));
      applyStimulus(y, res, e, edges);
      checkOutput($sformatf("rand_y%05h", y), real'(res), lnModel(y), 4.0);
      if (e !== 1'b0) checkOutput($sformatf("rand_err_y%05h", y), real'(e), 0.0, 0.0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
